mem_arbiter: RTL and testbench

- Shares the single unified instruction/data memory between two requesters: the core's multicycle fetch/load/store port and a debug/loader port that fills program memory and inspects state.
- Sits between the core and the memory instance. All memory enables, the address and the write data pass through it.
- Arbitration is one access per cycle with round-robin fairness. A debug lock gives the debug port exclusive multi-cycle ownership.
- A read-return tracker steers the 1-cycle-latency read data to the owning requester.

---
 rtl/mem_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of the unified instruction/data memory: core port vs. debug/loader port.
// One access per cycle, round-robin or debug-priority, with a debug lock and 1-cycle read-return steering.
`timescale 1ns/1ps

module mem_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 32,
    parameter bit DBG_PRIO = 1'b0
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_gnt,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,

    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,

    input  logic              dbg_lock,
    output logic              dbg_locked,

    output logic              mem_wen,
    output logic              mem_ren,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic {
        ST_ARB,
        ST_LOCKED
    } state_t;

    typedef enum logic {
        SRC_CORE,
        SRC_DBG
    } src_t;

    state_t state;
    src_t   last_gnt;

    // Grant decision is combinational so a requester is accepted in the cycle it asks.
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        core_gnt = 1'b0;
        dbg_gnt  = 1'b0;
        if (rst) begin
            if (state == ST_LOCKED) begin
                dbg_gnt = dbg_req;
            end else if (core_req && dbg_req) begin
                if (DBG_PRIO || last_gnt == SRC_CORE) begin
                    dbg_gnt = 1'b1;
                end else begin
                    core_gnt = 1'b1;
                end
            end else begin
                core_gnt = core_req;
                dbg_gnt  = dbg_req;
            end
        end
    end

    // Memory-side mux: idle cycles present all-zero address/data with both enables low.
    always_comb begin
        mem_wen   = 1'b0;
        mem_ren   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (core_gnt) begin
            mem_wen   = core_we;
            mem_ren   = ~core_we;
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
        end else if (dbg_gnt) begin
            mem_wen   = dbg_we;
            mem_ren   = ~dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_ARB;
            last_gnt    <= SRC_DBG;
            core_rvalid <= 1'b0;
            dbg_rvalid  <= 1'b0;
        end else begin
            case (state)
                ST_ARB: begin
                    if (dbg_lock && (dbg_gnt || !core_req)) begin
                        state <= ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (!dbg_lock) begin
                        state <= ST_ARB;
                    end
                end
                default: state <= ST_ARB;
            endcase

            if (core_gnt) begin
                last_gnt <= SRC_CORE;
            end else if (dbg_gnt) begin
                last_gnt <= SRC_DBG;
            end

            // Read-return owner: exactly one rvalid pulse, one cycle after a granted read.
            core_rvalid <= core_gnt & ~core_we;
            dbg_rvalid  <= dbg_gnt & ~dbg_we;
        end
    end

    assign dbg_locked = (state == ST_LOCKED);
    assign core_rdata = mem_rdata;
    assign dbg_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a round-robin and a debug-priority instance share all stimulus,
// each compared every cycle against a rule-level reference model, plus directed scenario checks.
`timescale 1ns/1ps

module tb_mem_arbiter;

    localparam int AW = 16;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          core_req, core_we, dbg_req, dbg_we, dbg_lock;
    logic [AW-1:0] core_addr, dbg_addr;
    logic [DW-1:0] core_wdata, dbg_wdata, mem_rdata;

    logic [1:0]         core_gnt, dbg_gnt, core_rvalid, dbg_rvalid, dbg_locked, mem_wen, mem_ren;
    logic [1:0][AW-1:0] mem_addr;
    logic [1:0][DW-1:0] mem_wdata, core_rdata, dbg_rdata;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DBG_PRIO(1'b0)) u_rr (
        .clk(clk), .rst(rst_n),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(core_gnt[0]), .core_rvalid(core_rvalid[0]), .core_rdata(core_rdata[0]),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt[0]), .dbg_rvalid(dbg_rvalid[0]), .dbg_rdata(dbg_rdata[0]),
        .dbg_lock(dbg_lock), .dbg_locked(dbg_locked[0]),
        .mem_wen(mem_wen[0]), .mem_ren(mem_ren[0]), .mem_addr(mem_addr[0]),
        .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata)
    );

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DBG_PRIO(1'b1)) u_pr (
        .clk(clk), .rst(rst_n),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(core_gnt[1]), .core_rvalid(core_rvalid[1]), .core_rdata(core_rdata[1]),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt[1]), .dbg_rvalid(dbg_rvalid[1]), .dbg_rdata(dbg_rdata[1]),
        .dbg_lock(dbg_lock), .dbg_locked(dbg_locked[1]),
        .mem_wen(mem_wen[1]), .mem_ren(mem_ren[1]), .mem_addr(mem_addr[1]),
        .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model, index 0 = round-robin instance, 1 = debug-priority instance.
    bit m_locked[2], m_last_dbg[2], m_rv_core[2], m_rv_dbg[2];
    bit e_cg[2], e_dg[2];
    logic [1:0] o_cg, o_dg, o_lk;
    logic [DW-1:0] ref_mem [logic [AW-1:0]];
    bit            pend_rd;
    logic [AW-1:0] pend_addr;

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            m_locked[p]   = 1'b0;
            m_last_dbg[p] = 1'b1;
            m_rv_core[p]  = 1'b0;
            m_rv_dbg[p]   = 1'b0;
        end
        pend_rd = 1'b0;
    endtask

    function automatic void model_grant(input int p, output bit cg, output bit dg);
        cg = 1'b0;
        dg = 1'b0;
        if (rst_n !== 1'b1) return;
        if (m_locked[p]) dg = dbg_req;
        else if (core_req && dbg_req) begin
            if (p == 1 || !m_last_dbg[p]) dg = 1'b1;
            else cg = 1'b1;
        end else begin
            cg = core_req;
            dg = dbg_req;
        end
    endfunction

    // Called at posedge+1 with inputs set; checks mid-cycle, advances one clock, returns at posedge+1.
    task automatic step(input bit rst_mid = 1'b0);
        bit cg, dg;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        #2;
        for (int p = 0; p < 2; p++) begin
            model_grant(p, cg, dg);
            e_cg[p] = cg;
            e_dg[p] = dg;
            ea = cg ? core_addr  : (dg ? dbg_addr  : '0);
            ed = cg ? core_wdata : (dg ? dbg_wdata : '0);
            o_cg[p] = core_gnt[p];
            o_dg[p] = dbg_gnt[p];
            o_lk[p] = dbg_locked[p];
            check($sformatf("p%0d core_gnt", p),    core_gnt[p],    cg);
            check($sformatf("p%0d dbg_gnt", p),     dbg_gnt[p],     dg);
            check($sformatf("p%0d mem_wen", p),     mem_wen[p],     (cg && core_we) || (dg && dbg_we));
            check($sformatf("p%0d mem_ren", p),     mem_ren[p],     (cg && !core_we) || (dg && !dbg_we));
            check($sformatf("p%0d mem_addr", p),    mem_addr[p],    ea);
            check($sformatf("p%0d mem_wdata", p),   mem_wdata[p],   ed);
            check($sformatf("p%0d core_rvalid", p), core_rvalid[p], m_rv_core[p]);
            check($sformatf("p%0d dbg_rvalid", p),  dbg_rvalid[p],  m_rv_dbg[p]);
            check($sformatf("p%0d dbg_locked", p),  dbg_locked[p],  m_locked[p]);
            if (m_rv_core[p]) check($sformatf("p%0d core_rdata", p), core_rdata[p], mem_rdata);
            if (m_rv_dbg[p])  check($sformatf("p%0d dbg_rdata", p),  dbg_rdata[p],  mem_rdata);
        end
        if (rst_mid) begin
            #1 rst_n = 1'b0;
            #0.5;
            for (int p = 0; p < 2; p++) begin
                check($sformatf("p%0d rst core_gnt", p),    core_gnt[p],    1'b0);
                check($sformatf("p%0d rst dbg_gnt", p),     dbg_gnt[p],     1'b0);
                check($sformatf("p%0d rst mem_en", p),      {mem_wen[p], mem_ren[p]}, 2'b00);
                check($sformatf("p%0d rst core_rvalid", p), core_rvalid[p], 1'b0);
                check($sformatf("p%0d rst dbg_locked", p),  dbg_locked[p],  1'b0);
            end
            model_reset();
            @(posedge clk);
            #1;
            return;
        end
        @(posedge clk);
        if (rst_n === 1'b1) begin
            for (int p = 0; p < 2; p++) begin
                m_locked[p]  = m_locked[p] ? dbg_lock : (dbg_lock && (e_dg[p] || !core_req));
                if (e_cg[p]) m_last_dbg[p] = 1'b0;
                else if (e_dg[p]) m_last_dbg[p] = 1'b1;
                m_rv_core[p] = e_cg[p] && !core_we;
                m_rv_dbg[p]  = e_dg[p] && !dbg_we;
            end
            pend_rd = 1'b0;
            if (e_cg[0]) begin
                if (core_we) ref_mem[core_addr] = core_wdata;
                else begin pend_rd = 1'b1; pend_addr = core_addr; end
            end else if (e_dg[0]) begin
                if (dbg_we) ref_mem[dbg_addr] = dbg_wdata;
                else begin pend_rd = 1'b1; pend_addr = dbg_addr; end
            end
        end
        #1;
        if (pend_rd) mem_rdata = ref_mem.exists(pend_addr) ? ref_mem[pend_addr] : {16'hA5A5, pend_addr};
        else mem_rdata = $urandom;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] lock_rd_val;
        rst_n = 1'b1;
        core_req = 1'b1; core_we = 1'b0; core_addr = '0; core_wdata = '0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
        dbg_lock = 1'b0; mem_rdata = '0;
        model_reset();
        ref_mem[16'h0000] = 32'h0000_0013;
        #0.5 rst_n = 1'b0;
        #0.5;
        // In reset with a pending core request: nothing granted.
        step();
        check("reset core_gnt", o_cg[0], 1'b0);
        rst_n = 1'b1;

        // First read after reset.
        step();
        check("t1 core_gnt", o_cg[0], 1'b1);
        core_req = 1'b0;
        #0.1;
        check("t1 core_rvalid", core_rvalid[0], 1'b1);
        check("t1 core_rdata",  core_rdata[0],  32'h0000_0013);
        check("t1 dbg_rvalid",  dbg_rvalid[0],  1'b0);
        step();

        // Debug write then core read-back of the same word.
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 16'h0100; dbg_wdata = 32'hDEAD_BEEF;
        step();
        check("t3 dbg_gnt", o_dg[0], 1'b1);
        dbg_req = 1'b0;
        core_req = 1'b1; core_we = 1'b0; core_addr = 16'h0100;
        step();
        check("t3 core_gnt", o_cg[0], 1'b1);
        core_req = 1'b0;
        #0.1;
        check("t3 core_rvalid", core_rvalid[0], 1'b1);
        check("t3 core_rdata",  core_rdata[0],  32'hDEAD_BEEF);
        // Lone debug read so the last grant is debug before the contention burst.
        dbg_req = 1'b1; dbg_we = 1'b0;
        step();

        // Both request every cycle: alternation vs. fixed debug priority.
        core_req = 1'b1; core_addr = 16'h0010;
        dbg_req  = 1'b1; dbg_addr  = 16'h0020;
        for (int i = 0; i < 6; i++) begin
            step();
            check($sformatf("rr%0d core_gnt", i), o_cg[0], (i % 2) == 0);
            check($sformatf("rr%0d dbg_gnt", i),  o_dg[0], (i % 2) == 1);
            check($sformatf("pr%0d dbg_gnt", i),  o_dg[1], 1'b1);
            check($sformatf("pr%0d core_gnt", i), o_cg[1], 1'b0);
        end

        // Lock raised together with a core request while debug went last: core wins first.
        core_addr = 16'h0200;
        dbg_lock = 1'b1; dbg_we = 1'b1;
        step();
        check("lock race core_gnt", o_cg[0], 1'b1);
        for (int i = 0; i < 4; i++) begin
            dbg_addr = AW'(16'h0300 + 4 * i);
            dbg_wdata = $urandom;
            if (i == 0) lock_rd_val = dbg_wdata;
            step();
            check($sformatf("lock%0d dbg_gnt", i),  o_dg[0], 1'b1);
            check($sformatf("lock%0d core_gnt", i), o_cg[0], 1'b0);
            if (i > 0) check($sformatf("lock%0d dbg_locked", i), o_lk[0], 1'b1);
        end
        // Drop the lock with a debug read in flight.
        dbg_lock = 1'b0; dbg_we = 1'b0; dbg_addr = 16'h0300;
        step();
        check("unlock dbg_gnt",  o_dg[0], 1'b1);
        check("unlock core_gnt", o_cg[0], 1'b0);
        dbg_req = 1'b0;
        #0.1;
        check("unlock dbg_rvalid", dbg_rvalid[0], 1'b1);
        check("unlock dbg_rdata",  dbg_rdata[0],  lock_rd_val);
        step();
        check("unlock core within 2", o_cg[0], 1'b1);
        core_req = 1'b0;
        step();

        // Reset asserted mid-cycle after a core read grant.
        core_req = 1'b1; core_we = 1'b0; core_addr = 16'h0004;
        step(1'b1);
        step();
        rst_n = 1'b1;
        #0.1;
        check("post-reset core_rvalid", core_rvalid[0], 1'b0);
        dbg_req = 1'b1; dbg_we = 1'b0;
        step();
        check("post-reset first contention core", o_cg[0], 1'b1);
        core_req = 1'b0; dbg_req = 1'b0;
        step();

        // Randomized traffic; payload held until the round-robin instance grants it.
        for (int n = 0; n < 400; n++) begin
            if (!core_req || e_cg[0]) begin
                core_req   = ($urandom_range(0, 3) != 0);
                core_we    = $urandom_range(0, 1) == 1;
                core_addr  = AW'($urandom_range(0, 15) * 4);
                core_wdata = $urandom;
            end
            if (!dbg_req || e_dg[0]) begin
                dbg_req   = ($urandom_range(0, 2) != 0);
                dbg_we    = $urandom_range(0, 1) == 1;
                dbg_addr  = AW'($urandom_range(0, 15) * 4);
                dbg_wdata = $urandom;
            end
            if ($urandom_range(0, 15) == 0) dbg_lock = ~dbg_lock;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
